decimator_multi: RTL and testbench

- Runtime-programmable, multi-channel decimator for the phase-noise sample path.
- Reduces the rate of NUM_CH lock-step sample streams, e.g. I/Q, by a ratio R selected at run time.
- Mode 0 (pick): forwards the first sample of each group of R valid samples.
- Mode 1 (boxcar): outputs the signed sum of each group of R samples.
- Sits between the ADC/mixer front end and the capture FIFO, replacing the fixed divide-by-10 sampler.

---
 rtl/decimator_multi.sv | 108 ++++++++++
 tb/tb_decimator_multi.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decimator_multi.sv
// rtl/decimator_multi.sv - runtime-programmable multi-channel pick/boxcar decimator
module decimator_multi #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_CH        = 2,
    parameter int MAX_RATIO     = 1024,
    parameter int DEFAULT_RATIO = 10,
    parameter int RATIO_WIDTH   = $clog2(MAX_RATIO + 1),
    parameter int OUT_WIDTH     = DATA_WIDTH + $clog2(MAX_RATIO)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_load,
    input  logic [RATIO_WIDTH-1:0]        cfg_ratio,
    input  logic                          cfg_mode,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  data_in,
    input  logic                          data_in_vld,
    output logic [NUM_CH*OUT_WIDTH-1:0]   data_out,
    output logic                          data_out_vld,
    output logic                          cfg_err
);

    logic [RATIO_WIDTH-1:0] ratio_r;
    logic [RATIO_WIDTH-1:0] idx_r;
    logic                   mode_r;

    logic [RATIO_WIDTH-1:0] eff_ratio;
    logic                   ratio_bad;
    logic [RATIO_WIDTH-1:0] cur_ratio;
    logic [RATIO_WIDTH-1:0] cur_idx;
    logic                   cur_mode;
    logic                   is_first;
    logic                   is_last;
    logic                   emit;

    logic [OUT_WIDTH-1:0]   acc_r      [NUM_CH];
    logic [OUT_WIDTH-1:0]   sample_ext [NUM_CH];
    logic [OUT_WIDTH-1:0]   sum_next   [NUM_CH];

    // Illegal ratios are clamped into the legal range rather than rejected.
    always_comb begin
        eff_ratio = cfg_ratio;
        ratio_bad = 1'b0;
        if (cfg_ratio == '0) begin
            eff_ratio = RATIO_WIDTH'(1);
            ratio_bad = 1'b1;
        end else if (cfg_ratio > RATIO_WIDTH'(MAX_RATIO)) begin
            eff_ratio = RATIO_WIDTH'(MAX_RATIO);
            ratio_bad = 1'b1;
        end
    end

    // A sample arriving with cfg_load already belongs to the new configuration.
    always_comb begin
        cur_ratio = cfg_load ? eff_ratio : ratio_r;
        cur_mode  = cfg_load ? cfg_mode  : mode_r;
        cur_idx   = cfg_load ? '0        : idx_r;
        is_first  = (cur_idx == '0);
        is_last   = (cur_idx == (cur_ratio - RATIO_WIDTH'(1)));
        emit      = data_in_vld && (cur_mode ? is_last : is_first);
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sample_ext[k] = {{(OUT_WIDTH-DATA_WIDTH){data_in[k*DATA_WIDTH + DATA_WIDTH - 1]}},
                             data_in[k*DATA_WIDTH +: DATA_WIDTH]};
            sum_next[k]   = (is_first ? '0 : acc_r[k]) + sample_ext[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ratio_r      <= RATIO_WIDTH'(DEFAULT_RATIO);
            mode_r       <= 1'b0;
            idx_r        <= '0;
            data_out     <= '0;
            data_out_vld <= 1'b0;
            cfg_err      <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_r[k] <= '0;
            end
        end else begin
            data_out_vld <= emit;
            if (cfg_load) begin
                ratio_r <= eff_ratio;
                mode_r  <= cfg_mode;
                idx_r   <= '0;
                if (ratio_bad) begin
                    cfg_err <= 1'b1;
                end
            end
            if (data_in_vld) begin
                idx_r <= is_last ? '0 : cur_idx + RATIO_WIDTH'(1);
                for (int k = 0; k < NUM_CH; k++) begin
                    if (!cur_mode) begin
                        if (is_first) begin
                            data_out[k*OUT_WIDTH +: OUT_WIDTH] <= sample_ext[k];
                        end
                    end else if (is_last) begin
                        data_out[k*OUT_WIDTH +: OUT_WIDTH] <= sum_next[k];
                    end else begin
                        acc_r[k] <= sum_next[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_decimator_multi.sv
// tb/tb_decimator_multi.sv - randomized self-checking bench for decimator_multi
module tb_decimator_multi;

    localparam int DW   = 32;
    localparam int NCH  = 2;
    localparam int MAXR = 1024;
    localparam int RW   = 11;
    localparam int OW   = 42;

    logic                clk;
    logic                rst;
    logic                cfg_load;
    logic [RW-1:0]       cfg_ratio;
    logic                cfg_mode;
    logic [NCH*DW-1:0]   data_in;
    logic                data_in_vld;
    logic [NCH*OW-1:0]   data_out;
    logic                data_out_vld;
    logic                cfg_err;

    int checks;
    int failures;

    int              m_ratio;
    bit              m_mode;
    bit              m_err;
    bit              exp_vld;
    logic [NCH*OW-1:0] exp_out;
    longint          grp [NCH][$];

    decimator_multi dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_load     (cfg_load),
        .cfg_ratio    (cfg_ratio),
        .cfg_mode     (cfg_mode),
        .data_in      (data_in),
        .data_in_vld  (data_in_vld),
        .data_out     (data_out),
        .data_out_vld (data_out_vld),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ratio = 10;
        m_mode  = 1'b0;
        m_err   = 1'b0;
        exp_vld = 1'b0;
        exp_out = '0;
        for (int k = 0; k < NCH; k++) grp[k].delete();
    endtask

    // Drive one cycle, then advance the group model: pick emits the first
    // sample of a group, boxcar emits the plain sum once the group is full.
    task automatic step(input bit load, input int ratio, input bit mode,
                        input bit vld, input int s0, input int s1);
        int     eff;
        longint smp [NCH];
        longint sum;
        cfg_load    = load;
        cfg_ratio   = RW'(ratio);
        cfg_mode    = mode;
        data_in_vld = vld;
        data_in     = {s1, s0};
        @(posedge clk);
        smp[0] = longint'(s0);
        smp[1] = longint'(s1);
        exp_vld = 1'b0;
        if (load) begin
            eff = (ratio == 0) ? 1 : (ratio > MAXR) ? MAXR : ratio;
            m_ratio = eff;
            m_mode  = mode;
            if (ratio == 0 || ratio > MAXR) m_err = 1'b1;
            for (int k = 0; k < NCH; k++) grp[k].delete();
        end
        if (vld) begin
            for (int k = 0; k < NCH; k++) grp[k].push_back(smp[k]);
            if (!m_mode && grp[0].size() == 1) begin
                exp_vld = 1'b1;
                for (int k = 0; k < NCH; k++) exp_out[k*OW +: OW] = smp[k][OW-1:0];
            end
            if (grp[0].size() == m_ratio) begin
                if (m_mode) begin
                    exp_vld = 1'b1;
                    for (int k = 0; k < NCH; k++) begin
                        sum = 0;
                        foreach (grp[k][i]) sum += grp[k][i];
                        exp_out[k*OW +: OW] = sum[OW-1:0];
                    end
                end
                for (int k = 0; k < NCH; k++) grp[k].delete();
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        cfg_load    = 1'b0;
        data_in_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (data_out_vld !== 1'b0 || data_out !== '0 || cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL reset vld=%b out=%h err=%b required 0/0/0", data_out_vld, data_out, cfg_err);
        end
    endtask

    task automatic test_pick_default();
        int strobes = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 1, i, int'($urandom()));
            if (data_out_vld) strobes++;
            checks++;
            if (data_out_vld !== exp_vld || data_out !== exp_out) begin
                failures++;
                $display("FAIL pick_default i=%0d vld=%b out=%h required vld=%b out=%h", i, data_out_vld, data_out, exp_vld, exp_out);
            end
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (strobes != 3) begin
            failures++;
            $display("FAIL pick_default_count got %0d required 3", strobes);
        end
    endtask

    task automatic test_boxcar_sum();
        longint got [$];
        step(1, 4, 1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 1, i, -i);
            if (data_out_vld) begin
                got.push_back(longint'($signed(data_out[0 +: OW])));
                got.push_back(longint'($signed(data_out[OW +: OW])));
            end
            checks++;
            if (data_out_vld !== exp_vld || data_out !== exp_out) begin
                failures++;
                $display("FAIL boxcar_sum i=%0d vld=%b out=%h required vld=%b out=%h", i, data_out_vld, data_out, exp_vld, exp_out);
            end
        end
        checks++;
        if (got.size() != 4 || got[0] != 10 || got[1] != -10 || got[2] != 26 || got[3] != -26) begin
            failures++;
            $display("FAIL boxcar_values got %0d values first=%0d required 10,-10,26,-26", got.size(), (got.size() > 0) ? got[0] : 0);
        end
    endtask

    task automatic test_gaps();
        int strobes = 0;
        step(1, 4, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, (i % 3 == 0) && (i < 12), 5, 5);
            if (data_out_vld) strobes++;
            checks++;
            if (data_out_vld !== exp_vld || data_out !== exp_out) begin
                failures++;
                $display("FAIL gaps i=%0d vld=%b out=%h required vld=%b out=%h", i, data_out_vld, data_out, exp_vld, exp_out);
            end
        end
        checks++;
        if (strobes != 1 || data_out[0 +: OW] !== OW'(20)) begin
            failures++;
            $display("FAIL gaps_result strobes=%0d out=%0d required 1 strobe of 20", strobes, data_out[0 +: OW]);
        end
    endtask

    task automatic test_cfg_midgroup();
        longint got [$];
        step(1, 10, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, int'($urandom()), int'($urandom()));
        for (int i = 0; i < 8; i++) begin
            step(i == 0, 3, 0, i < 6, 100 + i, -100 - i);
            if (data_out_vld) got.push_back(longint'($signed(data_out[0 +: OW])));
            checks++;
            if (data_out_vld !== exp_vld || data_out !== exp_out) begin
                failures++;
                $display("FAIL cfg_midgroup i=%0d vld=%b out=%h required vld=%b out=%h", i, data_out_vld, data_out, exp_vld, exp_out);
            end
        end
        checks++;
        if (got.size() != 2 || got[0] != 100 || got[1] != 103) begin
            failures++;
            $display("FAIL cfg_midgroup_values got %0d strobes first=%0d required 100,103", got.size(), (got.size() > 0) ? got[0] : 0);
        end
    endtask

    task automatic test_illegal_ratio();
        int strobes = 0;
        step(1, 0, $urandom_range(0, 1), 0, 0, 0);
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_zero_err got %b required 1", cfg_err);
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, $urandom_range(0, 1), int'($urandom()), int'($urandom()));
            checks++;
            if (data_out_vld !== exp_vld || data_out !== exp_out) begin
                failures++;
                $display("FAIL ratio_one i=%0d vld=%b out=%h required vld=%b out=%h", i, data_out_vld, data_out, exp_vld, exp_out);
            end
        end
        step(1, MAXR + 1, 1, 0, 0, 0);
        for (int i = 0; i < 2100; i++) begin
            step(0, 0, 0, 1, int'($urandom_range(0, 65535)) - 32768, int'($urandom()));
            if (data_out_vld) strobes++;
            checks++;
            if (data_out_vld !== exp_vld || data_out !== exp_out) begin
                failures++;
                $display("FAIL ratio_clamp i=%0d vld=%b out=%h required vld=%b out=%h", i, data_out_vld, data_out, exp_vld, exp_out);
            end
        end
        checks++;
        if (strobes != 2 || cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL ratio_clamp_summary strobes=%0d err=%b required 2 and 1", strobes, cfg_err);
        end
    endtask

    task automatic test_random();
        bit ld;
        int r;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            ld = ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 9) == 0) ? $urandom_range(1025, 2047) : $urandom_range(0, 12);
            step(ld, r, $urandom_range(0, 1), $urandom_range(0, 9) < 7, int'($urandom()), int'($urandom()));
            checks++;
            if (data_out_vld !== exp_vld || data_out !== exp_out || cfg_err !== m_err) begin
                failures++;
                $display("FAIL random i=%0d vld=%b out=%h err=%b required vld=%b out=%h err=%b", i, data_out_vld, data_out, cfg_err, exp_vld, exp_out, m_err);
            end
        end
    endtask

    task automatic test_max_sum_reset();
        longint big;
        big = 64'd1024 * 64'h7FFF_FFFF;
        apply_reset();
        step(1, MAXR, 1, 0, 0, 0);
        for (int i = 0; i < MAXR; i++) step(0, 0, 0, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        checks++;
        if (data_out_vld !== 1'b1 || data_out[0 +: OW] !== big[OW-1:0] || data_out[OW +: OW] !== big[OW-1:0]) begin
            failures++;
            $display("FAIL max_sum vld=%b out=%h required vld=1 each=%h", data_out_vld, data_out, big[OW-1:0]);
        end
        for (int i = 0; i < 300; i++) step(0, 0, 0, 1, int'($urandom()), int'($urandom()));
        rst = 1'b1;
        #1;
        checks++;
        if (data_out_vld !== 1'b0 || data_out !== '0) begin
            failures++;
            $display("FAIL async_reset vld=%b out=%h required 0/0", data_out_vld, data_out);
        end
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0, 0);
            checks++;
            if (data_out_vld !== 1'b0 || data_out !== '0) begin
                failures++;
                $display("FAIL late_strobe i=%0d vld=%b out=%h required 0/0", i, data_out_vld, data_out);
            end
        end
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        cfg_load    = 1'b0;
        cfg_ratio   = '0;
        cfg_mode    = 1'b0;
        data_in     = '0;
        data_in_vld = 1'b0;
        checks      = 0;
        failures    = 0;
        model_reset();
        test_reset();
        test_pick_default();
        test_boxcar_sum();
        test_gaps();
        test_cfg_midgroup();
        test_illegal_ratio();
        test_random();
        test_max_sum_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
